// File: rtl/mem_pipe.sv
// Parametrised single-port memory with valid/ready requests and fixed-latency in-order responses.
// Self-zeroes the array after reset or on clr, and flags addresses beyond DEPTH.
module mem_pipe #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 5,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_data,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_data,
  output logic              rsp_err,
  output logic              init_done
);

  localparam logic [AWIDTH:0]   DepthW   = (AWIDTH + 1)'(DEPTH);
  localparam logic [AWIDTH-1:0] LastAddr = AWIDTH'(DEPTH - 1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic              zero_we;
  logic              accept;
  logic              addr_err;
  logic [DWIDTH-1:0] stage0_data;

  logic [DWIDTH-1:0] mem [DEPTH];

  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] err_q;
  logic [DWIDTH-1:0] dat_q [RD_LAT];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    zero_we   = 1'b0;
    unique case (state_q)
      StInit: begin
        zero_we = 1'b1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastAddr) begin
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // clr takes priority over any request presented in the same cycle
        req_ready = !clr;
        if (clr) begin
          cnt_d   = '0;
          state_d = StInit;
        end
      end
      default: state_d = StInit;
    endcase
  end

  assign accept   = req_valid && req_ready;
  assign addr_err = {1'b0, req_addr} >= DepthW;

  always_comb begin
    stage0_data = '0;
    if (accept && !req_write && !addr_err) begin
      stage0_data = mem[req_addr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Array has no reset; INIT sweeps it to zero before any request is accepted.
  always_ff @(posedge clk) begin
    if (zero_we) begin
      mem[cnt_q] <= '0;
    end else if (accept && req_write && !addr_err) begin
      mem[req_addr] <= req_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      err_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= accept;
      err_q[0] <= accept && addr_err;
      dat_q[0] <= stage0_data;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign rsp_valid = vld_q[RD_LAT-1];
  assign rsp_err   = err_q[RD_LAT-1];
  assign rsp_data  = dat_q[RD_LAT-1];
  assign init_done = (state_q == StRun);

endmodule

// File: tb/tb_mem_pipe.sv
// Scoreboard bench for mem_pipe: two instances (32 words / latency 2, 24 words / latency 1).
// Drivers push expected responses; negedge monitors pop and compare.
module tb_mem_pipe;

  localparam int LatA = 2;
  localparam int LatB = 1;

  typedef struct {
    logic [7:0] data;
    logic       err;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  exp_t q_a[$];
  exp_t q_b[$];

  logic       clr_a = 1'b0, valid_a = 1'b0, write_a = 1'b0;
  logic [4:0] addr_a = '0;
  logic [7:0] wdata_a = '0;
  logic       ready_a, rvalid_a, rerr_a, done_a;
  logic [7:0] rdata_a;

  logic       clr_b = 1'b0, valid_b = 1'b0, write_b = 1'b0;
  logic [4:0] addr_b = '0;
  logic [7:0] wdata_b = '0;
  logic       ready_b, rvalid_b, rerr_b, done_b;
  logic [7:0] rdata_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_pipe #(.DWIDTH(8), .AWIDTH(5), .DEPTH(32), .RD_LAT(LatA)) u_a (
    .clk(clk), .rst(rst), .clr(clr_a), .req_valid(valid_a), .req_ready(ready_a),
    .req_write(write_a), .req_addr(addr_a), .req_data(wdata_a), .rsp_valid(rvalid_a),
    .rsp_data(rdata_a), .rsp_err(rerr_a), .init_done(done_a)
  );

  mem_pipe #(.DWIDTH(8), .AWIDTH(5), .DEPTH(24), .RD_LAT(LatB)) u_b (
    .clk(clk), .rst(rst), .clr(clr_b), .req_valid(valid_b), .req_ready(ready_b),
    .req_write(write_b), .req_addr(addr_b), .req_data(wdata_b), .rsp_valid(rvalid_b),
    .rsp_data(rdata_b), .rsp_err(rerr_b), .init_done(done_b)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic issue_a(input logic wr, input logic [4:0] a, input logic [7:0] d,
                         input logic [7:0] ed, input logic ee);
    exp_t e;
    valid_a = 1'b1; write_a = wr; addr_a = a; wdata_a = d;
    #1;
    chk("a_req_ready", ready_a, 1);
    e.data = ed; e.err = ee; e.cyc = cyc + LatA;
    q_a.push_back(e);
    @(posedge clk);
    @(negedge clk);
    valid_a = 1'b0;
  endtask

  task automatic issue_b(input logic wr, input logic [4:0] a, input logic [7:0] d,
                         input logic [7:0] ed, input logic ee);
    exp_t e;
    valid_b = 1'b1; write_b = wr; addr_b = a; wdata_b = d;
    #1;
    chk("b_req_ready", ready_b, 1);
    e.data = ed; e.err = ee; e.cyc = cyc + LatB;
    q_b.push_back(e);
    @(posedge clk);
    @(negedge clk);
    valid_b = 1'b0;
  endtask

  // Counts rising edges until each instance raises req_ready; call at a negedge.
  task automatic wait_init(input int exp_a, input int exp_b);
    int ea = 0;
    int eb = 0;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clk);
      #1;
      if (ready_a && ea == 0) ea = e;
      if (ready_b && eb == 0) eb = e;
      if (ea != 0 && eb != 0) break;
    end
    chk("a_init_edges", ea, exp_a);
    chk("b_init_edges", eb, exp_b);
    chk("a_init_done", done_a, 1);
    chk("b_init_done", done_b, 1);
    @(negedge clk);
  endtask

  task automatic drain;
    repeat (6) @(negedge clk);
    chk("a_queue_empty", q_a.size(), 0);
    chk("b_queue_empty", q_b.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rvalid_a) begin
      if (q_a.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_rsp: got rsp_valid=1 expected no response (t=%0t)", $time);
      end else begin
        e = q_a.pop_front();
        chk("a_rsp_data", rdata_a, e.data);
        chk("a_rsp_err", rerr_a, e.err);
        chk("a_rsp_cycle", cyc, e.cyc);
      end
    end else begin
      chk("a_idle_zero", {rerr_a, rdata_a}, 0);
    end
    if (rvalid_b) begin
      if (q_b.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_rsp: got rsp_valid=1 expected no response (t=%0t)", $time);
      end else begin
        e = q_b.pop_front();
        chk("b_rsp_data", rdata_b, e.data);
        chk("b_rsp_err", rerr_b, e.err);
        chk("b_rsp_cycle", cyc, e.cyc);
      end
    end else begin
      chk("b_idle_zero", {rerr_b, rdata_b}, 0);
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("a_reset_outs", {ready_a, rvalid_a, rerr_a, done_a, rdata_a}, 0);
    chk("b_reset_outs", {ready_b, rvalid_b, rerr_b, done_b, rdata_b}, 0);
    rst = 1'b0;
    wait_init(32, 24);

    // Fresh array reads zero
    issue_a(1'b0, 5'd7, 8'h00, 8'h00, 1'b0);
    drain();

    // Write then read next cycle, latency 2
    issue_a(1'b1, 5'd3, 8'hA5, 8'h00, 1'b0);
    issue_a(1'b0, 5'd3, 8'h00, 8'hA5, 1'b0);
    drain();

    // Stream writes and back-to-back reads over the full array
    for (int i = 0; i < 32; i++) issue_a(1'b1, 5'(i), 8'(i) ^ 8'hFF, 8'h00, 1'b0);
    for (int i = 0; i < 32; i++) issue_a(1'b0, 5'(i), 8'h00, 8'(i) ^ 8'hFF, 1'b0);
    issue_a(1'b0, 5'd9, 8'h00, 8'hF6, 1'b0);
    issue_a(1'b0, 5'd9, 8'h00, 8'hF6, 1'b0);
    drain();

    // Out-of-range and boundary addresses on the 24-word instance
    issue_b(1'b1, 5'd14, 8'h5A, 8'h00, 1'b0);
    issue_b(1'b1, 5'd30, 8'h11, 8'h00, 1'b1);
    issue_b(1'b0, 5'd30, 8'h00, 8'h00, 1'b1);
    issue_b(1'b0, 5'd14, 8'h00, 8'h5A, 1'b0);
    issue_b(1'b0, 5'd23, 8'h00, 8'h00, 1'b0);
    issue_b(1'b1, 5'd24, 8'h66, 8'h00, 1'b1);
    issue_b(1'b1, 5'd23, 8'h77, 8'h00, 1'b0);
    issue_b(1'b0, 5'd23, 8'h00, 8'h77, 1'b0);
    issue_b(1'b0, 5'd24, 8'h00, 8'h00, 1'b1);
    drain();

    // clr with two reads in flight: both still emerge, the clr-cycle read is dropped
    issue_a(1'b0, 5'd5, 8'h00, 8'hFA, 1'b0);
    issue_a(1'b0, 5'd6, 8'h00, 8'hF9, 1'b0);
    valid_a = 1'b1; write_a = 1'b0; addr_a = 5'd7; clr_a = 1'b1;
    #1;
    chk("a_clr_ready_low", ready_a, 0);
    @(posedge clk);
    @(negedge clk);
    valid_a = 1'b0; clr_a = 1'b0;
    #1;
    chk("a_clr_done_low", done_a, 0);
    begin
      int ea = 0;
      for (int e = 1; e <= 100; e++) begin
        @(posedge clk);
        #1;
        if (ready_a) begin ea = e; break; end
      end
      chk("a_clr_init_edges", ea, 32);
    end
    @(negedge clk);
    for (int i = 0; i < 32; i++) issue_a(1'b0, 5'(i), 8'h00, 8'h00, 1'b0);
    drain();

    // Reset mid-stream with responses in flight
    issue_a(1'b1, 5'd0, 8'h3C, 8'h00, 1'b0);
    issue_a(1'b1, 5'd31, 8'hC3, 8'h00, 1'b0);
    issue_a(1'b0, 5'd0, 8'h00, 8'h3C, 1'b0);
    issue_a(1'b0, 5'd31, 8'h00, 8'hC3, 1'b0);
    chk("a_valid_before_rst", rvalid_a, 1);
    #1;
    rst = 1'b1;
    #1;
    chk("a_rst_async_outs", {ready_a, rvalid_a, rerr_a, done_a, rdata_a}, 0);
    q_a.delete();
    q_b.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_init(32, 24);
    issue_a(1'b0, 5'd0, 8'h00, 8'h00, 1'b0);
    issue_a(1'b0, 5'd31, 8'h00, 8'h00, 1'b0);
    issue_b(1'b0, 5'd14, 8'h00, 8'h00, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_pipe.md
# mem_pipe

Parametrised single-port synchronous memory with a valid/ready request channel and an in-order, fixed-latency response channel; the next generation of the 32x8 lab memory behind the `mem_test` bench. It adds configurable width, depth and read latency, self-zeroing after reset or on request, and out-of-range address flagging. It sits behind the memory interface's memory-side modport; the test program drives the request side and checks responses.

## Interface
- DWIDTH, 8, data width in bits (1..64)
- AWIDTH, 5, address width in bits
- DEPTH, 32, number of words; must satisfy 2 <= DEPTH <= 2**AWIDTH
- RD_LAT, 1, response latency in cycles (1..4)

- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous request to re-zero the whole array
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_write  in  1  1 = write, 0 = read
- req_addr  in  AWIDTH  word address
- req_data  in  DWIDTH  write data
- rsp_valid  out  1  one-cycle response strobe
- rsp_data  out  DWIDTH  read data; 0 for writes and errored reads
- rsp_err  out  1  request address was >= DEPTH
- init_done  out  1  1 while in RUN state

## Operation
- States: INIT, RUN.
- rst asserted: state = INIT, zeroing counter = 0, response pipeline flushed. Array contents are don't-care until INIT completes.
- INIT: one location is written to 0 per cycle at the counter address, counter increments. After location DEPTH-1 is written, state goes to RUN. req_ready = 0 throughout INIT.
- RUN: req_ready = !clr. A request is accepted when req_valid && req_ready at a rising edge.
- Accepted write to address < DEPTH: req_data is stored at that edge.
- Accepted write to address >= DEPTH: nothing is stored; the response has rsp_err = 1.
- Accepted read: the array word is captured. For address >= DEPTH, rsp_data = 0 and rsp_err = 1.
- Every accepted request produces exactly one response. Responses are returned in request order, with no backpressure. Up to one request can be accepted per cycle, so throughput is 1 request/cycle.
- clr high in RUN: that cycle's request is not accepted (clr wins). State goes to INIT at that edge. Responses already in the pipeline still emerge on schedule.
- clr during INIT: ignored.
- rsp_data and rsp_err are 0 whenever rsp_valid = 0.

## Timing
- Reset values: req_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0, init_done = 0.
- After rst deasserts, INIT takes exactly DEPTH rising edges. req_ready and init_done go high after the DEPTH-th edge.
- A request accepted at edge N gives rsp_valid = 1 for the one cycle following edge N+RD_LAT-1. RD_LAT = 1 behaves like a classic synchronous RAM.
- Read-after-write: a write accepted at edge N is visible to a read accepted at edge N+1 or later.
- Back-to-back reads to the same address return identical data.
- rst asserted mid-operation: all outputs drop to reset values immediately (asynchronously). In-flight responses are discarded, and INIT restarts after rst deasserts.
- Address counter wrap: INIT stops at DEPTH-1. The counter never wraps into an unimplemented address.

## Test plan
- Reset then idle, with DEPTH = 32: req_ready stays 0 for 32 edges and rises after the 32nd edge; init_done likewise. A read of address 7 then returns 0x00 with rsp_err = 0.
- RD_LAT = 2, write 0xA5 to address 3, then read address 3 on the next cycle: the write response has rsp_data = 0 and rsp_err = 0; the read response comes 2 cycles after its acceptance with rsp_data = 0xA5.
- Streamed reads: write addresses 0..31 with value = addr^0xFF, then read 0..31 back-to-back. Expect 32 consecutive rsp_valid pulses, in order, all data correct.
- DEPTH = 24, AWIDTH = 5, write 0x11 to address 30, then read address 30: both responses have rsp_err = 1, and the read returns rsp_data = 0. Address 30 & 0x0F (= 14) is unchanged.
- Assert clr in the same cycle as a valid read while 2 reads are in flight: the new read is not accepted and the 2 in-flight responses arrive correctly. req_ready = 0 for DEPTH edges; afterwards every address reads 0x00.
- Assert rst mid-stream with responses in flight: rsp_valid goes to 0 at once and no stale response appears after release. INIT repeats for the full DEPTH cycles.
